// File: rtl/xentry_pkg.sv
// rtl/xentry_pkg.sv - shared cache-side enums: memory operation codes and L2 bridge FSM states
package xentry_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FLUSH = 2'd3
  } memory_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } l2_bridge_state_e;

endpackage

// File: rtl/xentry_watchdog_counter.sv
// rtl/xentry_watchdog_counter.sv - cycle watchdog; expired pulses on the LIMIT-th enabled cycle after clear
module xentry_watchdog_counter #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dcache_l2_bridge.sv
// rtl/dcache_l2_bridge.sv - word-serial bridge from dcache L2 requests to a valid/ready memory port
// Optional response watchdog enabled by defining L2_BRIDGE_TIMEOUT_EN.
module dcache_l2_bridge
  import xentry_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l2_req_valid,
  input  memory_operation_e l2_req_type,
  input  logic [ADDR_W-1:0] l2_req_address,
  input  logic [WORD_W-1:0] l2_req_store_word,
  output logic              l2_fetched_word_valid,
  output logic [WORD_W-1:0] l2_fetched_word,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [WORD_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [WORD_W-1:0] mem_rsp_rdata,
  output logic              mem_timeout_error
);

  l2_bridge_state_e state;
  logic             wd_expired;

`ifdef L2_BRIDGE_TIMEOUT_EN
  logic timeout_err_q;

  xentry_watchdog_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ST_ISSUE && mem_req_ready),
    .enable (state == ST_WAIT),
    .expired(wd_expired)
  );

  // A response on the expiry cycle wins, so the flag only records a true no-show.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else if (state == ST_WAIT && wd_expired && !mem_rsp_valid) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign mem_timeout_error = timeout_err_q;
`else
  assign wd_expired        = 1'b0;
  assign mem_timeout_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      mem_req_valid   <= 1'b0;
      mem_req_we      <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
      l2_fetched_word <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (l2_req_valid && (l2_req_type == LOAD || l2_req_type == STORE)) begin
            mem_req_addr  <= l2_req_address;
            mem_req_wdata <= l2_req_store_word;
            mem_req_we    <= (l2_req_type == STORE);
            mem_req_valid <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // mem_req_we still holds the latched type, so it doubles as the load/store select.
          if (mem_rsp_valid) begin
            if (!mem_req_we) begin
              l2_fetched_word <= mem_rsp_rdata;
            end
            state <= ST_DONE;
          end else if (wd_expired) begin
            l2_fetched_word <= '0;
            state           <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Gated by the live valid so a cache that has withdrawn sees no completion.
  assign l2_fetched_word_valid = (state == ST_DONE) && l2_req_valid;

endmodule

// File: tb/tb_dcache_l2_bridge.sv
// tb/tb_dcache_l2_bridge.sv - directed table-driven bench for dcache_l2_bridge
module tb_dcache_l2_bridge;
  import xentry_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [31:0]       l2_req_address;
  logic [31:0]       l2_req_store_word;
  logic              l2_fetched_word_valid;
  logic [31:0]       l2_fetched_word;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_rdata;
  logic              mem_timeout_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_l2_bridge #(
    .ADDR_W(32),
    .WORD_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .l2_req_valid         (l2_req_valid),
    .l2_req_type          (l2_req_type),
    .l2_req_address       (l2_req_address),
    .l2_req_store_word    (l2_req_store_word),
    .l2_fetched_word_valid(l2_fetched_word_valid),
    .l2_fetched_word      (l2_fetched_word),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_we           (mem_req_we),
    .mem_req_addr         (mem_req_addr),
    .mem_req_wdata        (mem_req_wdata),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_rdata        (mem_rsp_rdata),
    .mem_timeout_error    (mem_timeout_error)
  );

  typedef struct {
    memory_operation_e typ;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    int                rdy_dly;
    int                rsp_dly;
    bit                chained;
    bit                exp_we;
    logic [31:0]       exp_word;
    int                exp_lat;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(memory_operation_e t, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, int rdy, int rsp, bit ch, bit we,
                              logic [31:0] word, int lat);
    vec_t v;
    v.typ = t; v.addr = a; v.wdata = wd; v.rdata = rd; v.rdy_dly = rdy; v.rsp_dly = rsp;
    v.chained = ch; v.exp_we = we; v.exp_word = word; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pulse"}, l2_fetched_word_valid, 0);
    chk({tag, " word"}, l2_fetched_word, 0);
    chk({tag, " req_valid"}, mem_req_valid, 0);
    chk({tag, " we"}, mem_req_we, 0);
    chk({tag, " addr"}, mem_req_addr, 0);
    chk({tag, " wdata"}, mem_req_wdata, 0);
    chk({tag, " timeout"}, mem_timeout_error, 0);
  endtask

  // Acts as both cache and memory: drives the request, serves the handshake and
  // response with the vector's delays, and checks the pulse timing and data.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, stall, wcnt, issue_cyc;
    bit in_wait, hs_pend, rsp_on, done;
    if (!v.chained) begin
      l2_req_valid = 1'b0;
      @(negedge clk);
    end
    l2_req_valid = 1'b1; l2_req_type = v.typ;
    l2_req_address = v.addr; l2_req_store_word = v.wdata;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    cyc = 0; stall = 0; wcnt = 0; issue_cyc = -1;
    in_wait = 0; hs_pend = 0; rsp_on = 0; done = 0;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (hs_pend) begin hs_pend = 0; in_wait = 1; mem_req_ready = 1'b0; end
      if (rsp_on) begin rsp_on = 0; mem_rsp_valid = 1'b0; end
      if (l2_fetched_word_valid) begin
        done = 1;
        chk({tag, " issue_cycle"}, issue_cyc, v.chained ? 2 : 1);
        chk({tag, " latency"}, cyc - issue_cyc, v.exp_lat);
        chk({tag, " word"}, l2_fetched_word, v.exp_word);
      end else if (mem_req_valid) begin
        if (issue_cyc < 0) issue_cyc = cyc;
        chk({tag, " we"}, mem_req_we, v.exp_we);
        chk({tag, " addr"}, mem_req_addr, v.addr);
        chk({tag, " wdata"}, mem_req_wdata, v.wdata);
        if (stall >= v.rdy_dly) begin
          mem_req_ready = 1'b1; hs_pend = 1;
        end else begin
          stall++;
        end
      end else if (in_wait) begin
        if (wcnt >= v.rsp_dly) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata; rsp_on = 1; in_wait = 0;
        end else begin
          wcnt++;
        end
      end
    end
    if (!done) chk({tag, " pulse_seen"}, 0, 1);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(LOAD,  32'h40,  32'h0,  32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 2);
    vecs[1]  = mk(STORE, 32'h100, 32'hA0, 32'hBAD00000, 0, 0, 0, 1, 32'hDEADBEEF, 2);
    vecs[2]  = mk(STORE, 32'h101, 32'hA1, 32'hBAD00001, 0, 0, 1, 1, 32'hDEADBEEF, 2);
    vecs[3]  = mk(STORE, 32'h102, 32'hA2, 32'hBAD00002, 0, 0, 1, 1, 32'hDEADBEEF, 2);
    vecs[4]  = mk(STORE, 32'h103, 32'hA3, 32'hBAD00003, 0, 0, 1, 1, 32'hDEADBEEF, 2);
    vecs[5]  = mk(LOAD,  32'h200, 32'h0,  32'h10000200, 0, 0, 1, 0, 32'h10000200, 2);
    vecs[6]  = mk(LOAD,  32'h201, 32'h0,  32'h10000201, 0, 0, 1, 0, 32'h10000201, 2);
    vecs[7]  = mk(LOAD,  32'h202, 32'h0,  32'h10000202, 0, 0, 1, 0, 32'h10000202, 2);
    vecs[8]  = mk(LOAD,  32'h203, 32'h0,  32'h10000203, 0, 0, 1, 0, 32'h10000203, 2);
    vecs[9]  = mk(LOAD,  32'h300, 32'h77, 32'hCAFEF00D, 5, 0, 0, 0, 32'hCAFEF00D, 7);
    vecs[10] = mk(STORE, 32'h304, 32'h55, 32'hBAD00004, 0, 3, 0, 1, 32'hCAFEF00D, 5);
    vecs[11] = mk(LOAD,  32'h308, 32'h0,  32'h89ABCDEF, 2, 1, 0, 0, 32'h89ABCDEF, 5);

    reset = 1'b1; l2_req_valid = 1'b0; l2_req_type = NONE;
    l2_req_address = '0; l2_req_store_word = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Non-transfer types must never reach memory.
    l2_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l2_req_type = (i < 2) ? FLUSH : NONE;
      l2_req_address = 32'h900 + i;
      @(negedge clk);
      chk("ignore req_valid", mem_req_valid, 0);
      chk("ignore pulse", l2_fetched_word_valid, 0);
    end

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Cache withdraws valid while the bridge waits for the response.
    l2_req_valid = 1'b0;
    @(negedge clk);
    l2_req_valid = 1'b1; l2_req_type = LOAD; l2_req_address = 32'h500;
    @(negedge clk);
    chk("drop issue", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; l2_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h13572468;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("drop no_pulse", l2_fetched_word_valid, 0);
    @(negedge clk);
    chk("drop idle_req", mem_req_valid, 0);
    chk("drop idle_pulse", l2_fetched_word_valid, 0);
    chk("drop word", l2_fetched_word, 32'h13572468);

    // Reset while waiting, then a stale response arrives.
    l2_req_valid = 1'b1; l2_req_type = LOAD; l2_req_address = 32'h600;
    @(negedge clk);
    chk("rst issue", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; l2_req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBADBAD00;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk_reset_outputs("rst_wait");
    @(negedge clk);
    chk("rst_wait later_pulse", l2_fetched_word_valid, 0);
    run_vec(mk(LOAD, 32'h640, 32'h0, 32'h0F0F0F0F, 0, 0, 0, 0, 32'h0F0F0F0F, 2), "post_rst");

`ifdef L2_BRIDGE_TIMEOUT_EN
    run_vec(mk(LOAD, 32'h700, 32'h0, 32'hFFFFFFFF, 0, 100, 0, 0, 32'h0, 9), "timeout");
    chk("timeout flag", mem_timeout_error, 1);
    run_vec(mk(LOAD, 32'h704, 32'h0, 32'h24682468, 0, 0, 0, 0, 32'h24682468, 2), "after_to");
    chk("timeout sticky", mem_timeout_error, 1);
    l2_req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("timeout cleared", mem_timeout_error, 0);
`else
    chk("timeout tied", mem_timeout_error, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
